// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {ASSERT, RELEASE, DONE} rst_seq_state_t;

    typedef logic [1:0] rst_cause_t;

    localparam rst_cause_t CAUSE_POR = 2'b01;
    localparam rst_cause_t CAUSE_EXT = 2'b10;
    localparam rst_cause_t CAUSE_SW  = 2'b11;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser with asynchronous active-low clear.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Synchronises POR/push-button/software resets, stretches them, then releases
// N_OUT domain resets in index order. Define RST_SEQ_CAUSE_EN to add rst_cause.
import rst_seq_pkg::*;

module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int N_OUT          = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_rst_p,
    input  logic             sw_rst_p,
    output logic [N_OUT-1:0] rst_out_n,
`ifdef RST_SEQ_CAUSE_EN
    output logic [1:0]       rst_cause,
`endif
    output logic             rst_done
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_OUT) + 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_OUT - 1);

    logic por_sync, ext_req, por_req, req;

    sync_chain #(.STAGES(SYNC_STAGES)) u_por_sync (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (1'b1),
        .q     (por_sync)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_ext_sync (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (ext_rst_p),
        .q     (ext_req)
    );

    assign por_req = ~por_sync;
    assign req     = por_req | ext_req | sw_rst_p;

    rst_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_OUT-1:0] out_d;
    logic             done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_n <= '0;
            rst_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_n <= out_d;
            rst_done  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (req) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == STRETCH_LAST) begin
                        cnt_d   = '0;
                        idx_d   = IDX_W'(1);
                        state_d = (N_OUT > 1) ? RELEASE : DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE:    ;
                default: state_d = ASSERT;
            endcase
        end
    end

    // Outputs are computed one edge ahead so they leave flops directly.
    always_comb begin
        out_d  = rst_out_n;
        done_d = rst_done;
        if (req) begin
            out_d  = '0;
            done_d = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    out_d  = '0;
                    done_d = 1'b0;
                    if (cnt_q == STRETCH_LAST) begin
                        out_d  = N_OUT'(1);
                        done_d = (N_OUT == 1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        out_d  = rst_out_n | (N_OUT'(1) << idx_q);
                        done_d = (idx_q == IDX_LAST);
                    end
                end
                DONE: begin
                    out_d  = '1;
                    done_d = 1'b1;
                end
                default: begin
                    out_d  = '0;
                    done_d = 1'b0;
                end
            endcase
        end
    end

`ifdef RST_SEQ_CAUSE_EN
    rst_cause_t cause_d;

    always_comb begin
        cause_d = rst_cause;
        if (ext_req)       cause_d = CAUSE_EXT;
        else if (sw_rst_p) cause_d = CAUSE_SW;
        else if (por_req)  cause_d = CAUSE_POR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_cause <= CAUSE_POR;
        else        rst_cause <= cause_d;
    end
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output 2-flop reset synchroniser.
- Synchronises an asynchronous power-on reset and a push-button reset to clk, and accepts a synchronous software reset request.
- Stretches any reset for a minimum time, then releases N_OUT active-low domain resets one at a time in index order.
- Sits at the top level; its outputs feed the LED driver, scan logic and other datapath blocks.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for rst_n release and ext_rst_p; legal values >= 2.
- N_OUT, 4: number of sequenced reset outputs; legal values >= 1.
- STRETCH_CYCLES, 16: minimum clk cycles all outputs stay low after the last active request; legal values >= 1.
- STEP_CYCLES, 8: clk cycles between release of rst_out_n[k] and rst_out_n[k+1]; legal values >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low power-on reset; assertion is asynchronous, release is synchronised internally.
- ext_rst_p  input  1  asynchronous, active-high push-button reset.
- sw_rst_p  input  1  synchronous, active-high software reset request, clk domain; may be a single-cycle pulse.
- rst_out_n  output  N_OUT  sequenced active-low domain resets.
- rst_done  output  1  high when every rst_out_n bit is released.

Behaviour:
- Reset (rst_n low), asynchronous:
  - rst_out_n = 0, rst_done = 0, FSM = ASSERT, counter = 0.
  - All synchroniser flops are cleared to 0.
- POR synchroniser:
  - SYNC_STAGES flops, async-cleared by rst_n, shifting in 1.
  - Internal por_req = ~last stage.
  - Edge 1 is the first rising clk edge with rst_n high. por_req is sampled high up to and including edge SYNC_STAGES.
- ext synchroniser:
  - SYNC_STAGES flops on ext_rst_p, async-cleared by rst_n.
  - ext_req = last stage.
- req = por_req | ext_req | sw_rst_p.
- FSM states: ASSERT, RELEASE, DONE.
  - ASSERT: all outputs low.
    - req high at an edge: counter = 0.
    - Otherwise counter increments.
    - Counter reaching STRETCH_CYCLES: rst_out_n[0] = 1, idx = 1, counter = 0. Go to RELEASE if N_OUT > 1, else DONE with rst_done = 1.
  - RELEASE: counter increments.
    - Counter reaching STEP_CYCLES: rst_out_n[idx] = 1, idx++, counter = 0.
    - When the last bit is released, go to DONE and set rst_done = 1 on the same edge.
  - DONE: hold. rst_out_n = all ones, rst_done = 1.
- Any state with req sampled high at edge e:
  - After edge e: rst_out_n = 0, rst_done = 0, FSM = ASSERT, counter = 0.
  - This is a registered response: exactly 1 cycle, no combinational path from inputs to outputs.
- Timing from the last edge e with req high:
  - rst_out_n[k] rises after edge e + STRETCH_CYCLES + k*STEP_CYCLES.
  - rst_done rises with rst_out_n[N_OUT-1].
  - For POR, e = SYNC_STAGES.
- Release is monotonic: once released, bits stay high until the next req or rst_n. Bit k never releases before bit k-1.
- req held high: counter held at 0, outputs held low indefinitely.
- req during RELEASE: all bits already released drop on the next edge and the sequence restarts from ASSERT.
- Counter width: $clog2(max(STRETCH_CYCLES, STEP_CYCLES) + 1). Saturation is never needed.
- idx width: $clog2(N_OUT) + 1.
- All outputs come directly from flops, for glitch-free use as resets.

Optional Feature:
- Macro RST_SEQ_CAUSE_EN.
- Defined:
  - Adds output rst_cause, 2 bits, sticky.
  - Encoding: 2'b01 = POR, 2'b10 = EXT, 2'b11 = SW.
  - Cleared to 2'b01 by rst_n.
  - On entry to ASSERT due to a request, it records the highest-priority active source. Priority: EXT > SW > POR.
  - While in ASSERT, it updates on every edge where the recorded request is high.
- Undefined: the port and register are absent, and behaviour is otherwise identical.

Decomposition:
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {ASSERT, RELEASE, DONE} rst_seq_state_t.
  - typedef logic [1:0] rst_cause_t.
  - Cause localparams CAUSE_POR, CAUSE_EXT, CAUSE_SW.
- One sub-module: sync_chain, parametrised by STAGES, with an async active-low clear and 1-bit data. It is instantiated twice: for the POR release (d = 1) and for ext_rst_p.

Test Plan:
- POR, defaults: release rst_n before edge 1 → rst_out_n = 4'b0000 through edge 18; 4'b0001 after edge 18; 4'b0011 after 26; 4'b0111 after 34; 4'b1111 and rst_done = 1 after 42.
- In DONE, 1-cycle sw_rst_p at edge e → rst_out_n = 0 after e; bit0 after e+16; rst_done after e+40. With the macro: rst_cause = 2'b11.
- ext_rst_p high for 50 cycles mid-RELEASE (2 bits up) → outputs drop within SYNC_STAGES+1 edges and stay 0. Bit0 rises 16 edges after the last sampled ext_req. With the macro: rst_cause = 2'b10.
- rst_n pulsed low between edges mid-RELEASE → outputs 0 immediately, asynchronously, without a clk edge. Full POR timing is repeated afterwards.
- N_OUT = 1, STRETCH_CYCLES = 1, SYNC_STAGES = 3 → rst_out_n[0] and rst_done both rise after edge 4. The RELEASE state is never entered (check by assertion).
- Simultaneous sw_rst_p and ext_req during ASSERT → counter stays 0. Assertion checks throughout: monotonic release order, rst_done == &rst_out_n.
